// File: rtl/sram_port_arbiter_if.sv
// Bundle between the SRAM port arbiter, its requesters and the shared memory.
// The arbiter takes the slave modport; requesters and the memory side use master.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 4,
  parameter int DW      = 64
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_data;
  logic                  mem_enable;
  logic                  mem_wr_en;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_write_data;
  logic [DW-1:0]         mem_read_data;
  logic                  lock_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_wr, req_lock, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_data, mem_enable, mem_wr_en, mem_addr,
           mem_write_data, lock_err, busy
  );

  modport master (
    output req_valid, req_wr, req_lock, req_addr, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, mem_enable, mem_wr_en, mem_addr,
           mem_write_data, lock_err, busy
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters,
// with registered memory commands, fixed-latency read return and an RMW lock.
module sram_port_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int AW       = 4,
  parameter int DW       = 64,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_port_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  // Arbitration and lock state
  logic [IW-1:0] last_grant_reg;
  logic          lock_active_reg;
  logic [IW-1:0] lock_owner_reg;
  logic [CW-1:0] lock_cnt_reg;
  logic          lock_err_reg;

  // Registered memory command
  logic          mem_enable_reg;
  logic          mem_wr_en_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;

  // Read return pipe: stage k is visible k+1 cycles after the accept
  logic [RD_LAT:0] pipe_valid_reg;
  logic [IW-1:0]   pipe_owner_reg [RD_LAT+1];

  logic [AW-1:0] addr_arr  [NUM_REQ];
  logic [DW-1:0] wdata_arr [NUM_REQ];

  logic [IW:0]   rr_sum;
  logic [IW-1:0] rr_idx;
  logic          rr_found;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          sel_wr;
  logic          sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          force_release;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]       = bus.req_addr[gi*AW +: AW];
      assign wdata_arr[gi]      = bus.req_wdata[gi*DW +: DW];
      assign bus.req_ready[gi]  = grant_valid && (grant_idx == IW'(gi));
      assign bus.rsp_valid[gi]  = pipe_valid_reg[RD_LAT] && (pipe_owner_reg[RD_LAT] == IW'(gi));
    end
  endgenerate

  // Search begins one past the last winner; sum stays below 2*NUM_REQ so one wrap suffices
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_grant_reg} + (IW+1)'(k);
      if (rr_sum >= (IW+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IW+1)'(NUM_REQ);
      end
      if (!rr_found && bus.req_valid[rr_sum[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    grant_idx   = rr_idx;
    grant_valid = rr_found;
    if (lock_active_reg) begin
      grant_idx   = lock_owner_reg;
      grant_valid = bus.req_valid[lock_owner_reg];
    end
    // req_ready must read zero for as long as reset is held
    if (!rst_n) begin
      grant_valid = 1'b0;
    end
  end

  assign sel_wr        = bus.req_wr[grant_idx];
  assign sel_lock      = bus.req_lock[grant_idx];
  assign sel_addr      = addr_arr[grant_idx];
  assign sel_wdata     = wdata_arr[grant_idx];
  assign force_release = lock_active_reg && !grant_valid &&
                         (lock_cnt_reg == CW'(LOCK_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg  <= IW'(NUM_REQ - 1);
      lock_active_reg <= 1'b0;
      lock_owner_reg  <= '0;
      lock_cnt_reg    <= '0;
      lock_err_reg    <= 1'b0;
    end else begin
      lock_err_reg <= 1'b0;
      if (grant_valid) begin
        // Under a lock only the owner can be granted, so this both takes and drops ownership
        last_grant_reg  <= grant_idx;
        lock_cnt_reg    <= '0;
        lock_active_reg <= sel_lock;
        if (sel_lock) begin
          lock_owner_reg <= grant_idx;
        end
      end else if (lock_active_reg) begin
        if (force_release) begin
          lock_active_reg <= 1'b0;
          lock_cnt_reg    <= '0;
          lock_err_reg    <= 1'b1;
        end else begin
          lock_cnt_reg <= lock_cnt_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_enable_reg <= 1'b0;
      mem_wr_en_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      mem_enable_reg <= grant_valid;
      mem_wr_en_reg  <= grant_valid && sel_wr;
      if (grant_valid) begin
        mem_addr_reg  <= sel_addr;
        mem_wdata_reg <= sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        pipe_owner_reg[k] <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= grant_valid && !sel_wr;
      pipe_owner_reg[0] <= grant_idx;
      for (int k = 1; k <= RD_LAT; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
        pipe_owner_reg[k] <= pipe_owner_reg[k-1];
      end
    end
  end

  assign bus.mem_enable     = mem_enable_reg;
  assign bus.mem_wr_en      = mem_wr_en_reg;
  assign bus.mem_addr       = mem_addr_reg;
  assign bus.mem_write_data = mem_wdata_reg;
  assign bus.rsp_data       = bus.mem_read_data;
  assign bus.lock_err       = lock_err_reg;
  assign bus.busy           = lock_active_reg || (|pipe_valid_reg);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, single read, ordering, fairness,
// locked RMW, lock timeout and reset during an in-flight read.
module tb_sram_port_arbiter;
  localparam int NUM_REQ  = 2;
  localparam int AW       = 4;
  localparam int DW       = 64;
  localparam int RD_LAT   = 1;
  localparam int LOCK_MAX = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // Single-port memory, one cycle read latency, write-first
  logic [DW-1:0] mem [16] = '{64'h0, 64'h11, 64'h22, 64'hA5, 64'h0, 64'h55, 64'h0, 64'h0,
                              64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
  logic [DW-1:0] rd_q = '0;

  sram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  sram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_read_data = rd_q;

  always @(posedge clk) begin
    if (bus.mem_enable) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_write_data;
      else               rd_q <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_wr[i]             = wr;
    bus.req_lock[i]           = lk;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_lock  = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values, with requests already pending
    #1 rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #2;
    $display("step reset");
    check("rst_ready",   64'(bus.req_ready), 64'h0);
    check("rst_rsp",     64'(bus.rsp_valid), 64'h0);
    check("rst_men",     64'(bus.mem_enable), 64'h0);
    check("rst_mwr",     64'(bus.mem_wr_en), 64'h0);
    check("rst_maddr",   64'(bus.mem_addr), 64'h0);
    check("rst_mwdata",  bus.mem_write_data, 64'h0);
    check("rst_lockerr", 64'(bus.lock_err), 64'h0);
    check("rst_busy",    64'(bus.busy), 64'h0);
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Single read of address 3
    tick(); set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 64'h0); #1;
    $display("step single read req0 addr 3");
    check("rd_ready", 64'(bus.req_ready), 64'h1);
    tick(); idle(); #1;
    check("rd_men",   64'(bus.mem_enable), 64'h1);
    check("rd_mwr",   64'(bus.mem_wr_en), 64'h0);
    check("rd_maddr", 64'(bus.mem_addr), 64'h3);
    check("rd_rsp0",  64'(bus.rsp_valid), 64'h0);
    check("rd_busy",  64'(bus.busy), 64'h1);
    tick(); #1;
    check("rd_rsp",   64'(bus.rsp_valid), 64'h1);
    check("rd_data",  bus.rsp_data, 64'hA5);
    tick(); #1;
    check("rd_rsp_end", 64'(bus.rsp_valid), 64'h0);
    check("rd_men_end", 64'(bus.mem_enable), 64'h0);
    check("rd_busy_end", 64'(bus.busy), 64'h0);

    // Back-to-back reads from different owners return in issue order
    tick(); set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 64'h0); #1;
    $display("step ordering req0 addr 1 then req1 addr 2");
    check("ord_ready0", 64'(bus.req_ready), 64'h1);
    tick(); idle(); set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 64'h0); #1;
    check("ord_ready1", 64'(bus.req_ready), 64'h2);
    check("ord_maddr0", 64'(bus.mem_addr), 64'h1);
    tick(); idle(); #1;
    check("ord_rsp0",   64'(bus.rsp_valid), 64'h1);
    check("ord_data0",  bus.rsp_data, 64'h11);
    check("ord_men1",   64'(bus.mem_enable), 64'h1);
    check("ord_maddr1", 64'(bus.mem_addr), 64'h2);
    tick(); #1;
    check("ord_rsp1",   64'(bus.rsp_valid), 64'h2);
    check("ord_data1",  bus.rsp_data, 64'h22);
    check("ord_men_end", 64'(bus.mem_enable), 64'h0);

    // Fairness: both valid for six cycles, grants alternate starting at req0
    tick(); set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 64'h0); set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 64'h0);
    $display("step fairness six cycles");
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      #1;
      check("fair_ready", 64'(bus.req_ready), 64'((c % 2 == 0) ? 1 : 2));
      if (c > 0) check("fair_men", 64'(bus.mem_enable), 64'h1);
      if (c > 1) begin
        check("fair_rsp",  64'(bus.rsp_valid), 64'((c % 2 == 0) ? 1 : 2));
        check("fair_data", bus.rsp_data, (c % 2 == 0) ? 64'h11 : 64'h22);
      end
    end
    tick(); idle(); #1;
    check("fair_men6",  64'(bus.mem_enable), 64'h1);
    check("fair_addr6", 64'(bus.mem_addr), 64'h2);
    check("fair_rsp6",  64'(bus.rsp_valid), 64'h1);
    tick(); #1;
    check("fair_men7",  64'(bus.mem_enable), 64'h0);
    check("fair_rsp7",  64'(bus.rsp_valid), 64'h2);
    check("fair_data7", bus.rsp_data, 64'h22);
    tick(); #1;
    check("fair_busy8", 64'(bus.busy), 64'h0);

    // Locked read-modify-write by req1 while req0 waits
    tick(); set_req(1, 1'b1, 1'b0, 1'b1, 4'd5, 64'h0); #1;
    $display("step lock rmw req1 addr 5");
    check("rmw_ready_rd", 64'(bus.req_ready), 64'h2);
    tick(); set_req(1, 1'b0, 1'b0, 1'b0, 4'd5, 64'h0); set_req(0, 1'b1, 1'b0, 1'b0, 4'd5, 64'h0); #1;
    check("rmw_ready_hold", 64'(bus.req_ready), 64'h0);
    check("rmw_busy",       64'(bus.busy), 64'h1);
    tick(); set_req(1, 1'b1, 1'b1, 1'b0, 4'd5, 64'h5A); #1;
    check("rmw_ready_wr", 64'(bus.req_ready), 64'h2);
    check("rmw_rsp",      64'(bus.rsp_valid), 64'h2);
    check("rmw_rdata",    bus.rsp_data, 64'h55);
    tick(); set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0); #1;
    check("rmw_ready_req0", 64'(bus.req_ready), 64'h1);
    check("rmw_men",        64'(bus.mem_enable), 64'h1);
    check("rmw_mwr",        64'(bus.mem_wr_en), 64'h1);
    check("rmw_maddr",      64'(bus.mem_addr), 64'h5);
    check("rmw_mwdata",     bus.mem_write_data, 64'h5A);
    check("rmw_lockerr",    64'(bus.lock_err), 64'h0);
    tick(); idle(); #1;
    check("rmw_rd_mwr",   64'(bus.mem_wr_en), 64'h0);
    check("rmw_rd_maddr", 64'(bus.mem_addr), 64'h5);
    tick(); #1;
    check("rmw_new_rsp",  64'(bus.rsp_valid), 64'h1);
    check("rmw_new_data", bus.rsp_data, 64'h5A);

    // Lock timeout: req1 locks and goes idle, req0 waits
    tick(); set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 64'h0); set_req(1, 1'b1, 1'b0, 1'b1, 4'd2, 64'h0); #1;
    $display("step lock timeout");
    check("to_ready_lock", 64'(bus.req_ready), 64'h2);
    tick(); set_req(1, 1'b0, 1'b0, 1'b0, 4'd2, 64'h0);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) tick();
      #1;
      check("to_ready_held", 64'(bus.req_ready), 64'h0);
      check("to_lockerr_lo", 64'(bus.lock_err), 64'h0);
    end
    tick(); #1;
    check("to_lockerr", 64'(bus.lock_err), 64'h1);
    check("to_ready0",  64'(bus.req_ready), 64'h1);
    check("to_busy",    64'(bus.busy), 64'h0);
    tick(); idle(); #1;
    check("to_lockerr_end", 64'(bus.lock_err), 64'h0);
    check("to_men",   64'(bus.mem_enable), 64'h1);
    check("to_maddr", 64'(bus.mem_addr), 64'h1);
    tick(); #1;
    check("to_rsp",  64'(bus.rsp_valid), 64'h1);
    check("to_data", bus.rsp_data, 64'h11);

    // Reset while a read is in flight
    tick(); set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 64'h0); #1;
    $display("step reset mid-read");
    check("mr_ready", 64'(bus.req_ready), 64'h2);
    tick(); set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 64'h0); set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 64'h0);
    rst_n = 1'b0; #1;
    check("mr_ready_rst", 64'(bus.req_ready), 64'h0);
    check("mr_men",       64'(bus.mem_enable), 64'h0);
    check("mr_maddr",     64'(bus.mem_addr), 64'h0);
    check("mr_busy",      64'(bus.busy), 64'h0);
    rst_n = 1'b1; #1;
    check("mr_first_grant", 64'(bus.req_ready), 64'h1);
    tick(); #1;
    check("mr_no_rsp", 64'(bus.rsp_valid), 64'h0);
    check("mr_men2",   64'(bus.mem_enable), 64'h1);
    check("mr_maddr2", 64'(bus.mem_addr), 64'h1);
    idle();
    tick(); #1;
    check("mr_rsp",  64'(bus.rsp_valid), 64'h1);
    check("mr_data", bus.rsp_data, 64'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port register-file/SRAM (memory-interface style: enable, wr_en, addr, write_data, read_data) among NUM_REQ requesters.
- Typical requesters are the APB register block's table port and hardware engines.
- Registers the winning command onto the memory port and routes read data back to the owner with a fixed-latency response.
- Supports a lock so one requester can perform atomic read-modify-write sequences.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
AW, 4, memory address width
DW, 64, memory data width
RD_LAT, 1, memory read latency in cycles from mem_enable to mem_read_data valid (1..3)
LOCK_MAX, 16, maximum consecutive cycles a lock may be held before forced release

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester command valid
req_ready  output  NUM_REQ  per-requester command accept (one-hot or zero)
req_wr  input  NUM_REQ  1 = write, 0 = read
req_lock  input  NUM_REQ  keep ownership after this beat
req_addr  input  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  input  NUM_REQ*DW  packed write data
rsp_valid  output  NUM_REQ  read data valid for requester i
rsp_data  output  DW  read data, shared by all requesters
mem_enable  output  1  memory access strobe
mem_wr_en  output  1  memory write
mem_addr  output  AW  memory address
mem_write_data  output  DW  memory write data
mem_read_data  input  DW  memory read data
lock_err  output  1  one-cycle pulse on forced lock release
busy  output  1  lock held or read in flight

Behaviour:
- Interface: one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, mem_enable=0, mem_wr_en=0, mem_addr=0, mem_write_data=0, lock_err=0, busy=0.
- Reset internal state: RR pointer to NUM_REQ-1, so requester 0 wins first. Lock is cleared and the response pipe is flushed.
- Reset mid-operation drops in-flight reads; no rsp_valid is issued for them.

Arbitration:
- Combinational in cycle T. Search starts at (last_grant+1) mod NUM_REQ.
- The first asserted req_valid gets req_ready; at most one ready bit is high.
- Accept = req_valid & req_ready. On accept, last_grant <= i.
- Requesters must hold valid, wr, addr and wdata stable until accepted.

Lock:
- An accepted beat with req_lock=1 makes i the owner. Only the owner may be granted; all other ready bits are 0.
- Ownership ends on the owner's accepted beat with req_lock=0. That beat is still granted.
- lock_cnt increments every cycle while the lock is held and clears on each owner accept.
- At lock_cnt==LOCK_MAX-1 the lock is force-released, lock_err pulses for 1 cycle, and normal RR resumes the next cycle.

Memory command and read response:
- Accept in cycle T. In T+1: mem_enable=1, mem_wr_en=req_wr, mem_addr=req_addr, mem_write_data=req_wdata, all registered from T.
- mem_enable is 0 in any cycle with no accept in the prior cycle. Throughput is 1 access per cycle.
- Reads: an RD_LAT+1 deep shift pipe carries {valid, owner}.
- rsp_valid[owner]=1 and rsp_data=mem_read_data (pass-through) in cycle T+1+RD_LAT. Default latency is 2.
- Writes produce no response.
- rsp_data is don't-care when no rsp_valid bit is set. Back-to-back reads from different owners return in issue order.
- busy = lock held OR any valid entry in the read pipe.

Simultaneous events:
- All-requesters-valid rotates strictly: 0,1,..,N-1,0.
- A write followed by a read of the same address in the next cycle returns the new data; the memory is write-first in order.

Test Plan:
- Single read: req0 read addr 3 (memory[3]=64'hA5) accepted at T -> mem_enable=1, wr_en=0, addr=3 at T+1; rsp_valid=2'b01, rsp_data=64'hA5 at T+2.
- Fairness: both requesters valid continuously for 6 cycles -> grants 0,1,0,1,0,1; mem_enable high on 6 consecutive cycles.
- Lock RMW: req1 read addr 5 with lock=1, then write addr 5 with lock=0 while req0 is valid throughout -> req0 ready=0 until req1's write is accepted; req0 granted the next cycle.
- Lock timeout: LOCK_MAX=16, req1 locks then idles -> after 16 cycles lock_err pulses once and req0 is granted next cycle.
- Ordering: req0 read addr 1 (=0x11) at T, req1 read addr 2 (=0x22) at T+1 -> rsp_valid=01 with 0x11 at T+2; rsp_valid=10 with 0x22 at T+3.
- Reset mid-read: rst_n low in cycle T+1 after a read accept -> all outputs 0 immediately; no rsp_valid after release; first grant goes to req0.
